xy2_100_tx: RTL and testbench
=============================

Name: xy2_100_tx

Overview:
- Serial XY2-100 galvo transmitter directly downstream of the scan-source multiplexer.
- Consumes the selected coordinate stream (xy2_send, x_coord, y_coord) and emits continuous 20-bit XY2-100 frames on CLK/SYNC/X/Y lines toward the LVDS output buffers.
- Frames repeat the last coordinate when no new sample has arrived, as the protocol requires a continuous stream.

Parameters:
- HALF_PERIOD, 25, clk cycles per half XY2 clock period (25 at 100 MHz gives a 2 MHz bit clock and a 100 kHz frame rate); legal range ≥2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tx_en  in  1  level; 1 = transmit frames continuously.
- xy2_send  in  1  sample-valid; captures x_coord/y_coord in every cycle it is 1.
- x_coord  in  16  X position, unsigned.
- y_coord  in  16  Y position, unsigned.
- xy2_clk  out  1  XY2 bit clock.
- xy2_sync  out  1  frame sync.
- xy2_x  out  1  X channel serial data.
- xy2_y  out  1  Y channel serial data.
- coord_ack  out  1  one-cycle pulse when a pending sample is loaded into a frame.
- busy  out  1  1 while a frame is in progress.

Behaviour:
- Reset (asynchronous assert, synchronous release): all outputs 0. State IDLE. Pending buffer empty. Held coordinates are 0x0000/0x0000. Divider and bit index are 0.
- Pending buffer: one 2x16 register plus a valid flag. A cycle with xy2_send=1 overwrites it and sets valid. The newest sample wins.
- States:
  - IDLE: outputs 0. On tx_en=1, go to LOAD.
  - LOAD (1 cycle): if valid, copy pending into the held registers, clear valid, pulse coord_ack. Build both 20-bit frames from the held values. Go to RUN.
  - RUN: shift out the frames. At the end of bit 19, go to LOAD if tx_en=1, otherwise go to IDLE.
- Frame layout, MSB first:
  - bits 0-2: control 0,0,1.
  - bits 3-18: coord[15:0].
  - bit 19: even parity, chosen so the total count of ones in the 20 bits is even.
- Bit timing:
  - Each bit lasts 2*HALF_PERIOD cycles: xy2_clk=1 for the first half, 0 for the second.
  - Data and sync change only together with the xy2_clk rising edge; the receiver samples on the falling edge.
  - xy2_sync=1 for bits 0-18 and 0 during bit 19.
  - Frame length is exactly 40*HALF_PERIOD + 1 cycles including LOAD (1001 at the default).
- busy=1 in LOAD and RUN.
- Simultaneous events:
  - xy2_send in the LOAD cycle: the load uses the pre-cycle pending value and the new sample stays pending (valid=1).
  - When valid=0 at LOAD, the previous held value is retransmitted and coord_ack stays 0.
- tx_en deasserted mid-frame: the current frame completes untruncated; outputs then return to 0.
- Reset mid-frame: outputs drop to 0 immediately and the pending sample is discarded.
- Latency from xy2_send to the first X data bit on the wire: at most one frame plus 2 cycles.

Optional Feature:
- XY2_STATUS_EN defined adds two outputs:
  - overrun_cnt [15:0]: increments, saturating at 0xFFFF, on each xy2_send that overwrites a still-valid pending sample.
  - frame_cnt [31:0]: increments, wrapping, at each LOAD.
  - Both reset to 0.
- XY2_STATUS_EN undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package xy2_pkg:
  - FRAME_BITS=20, CTRL_BITS=3'b001.
  - Function xy2_frame(coord) returning the 20-bit frame with parity.
- Sub-module xy2_frame_shift: a 20-bit load/shift register with serial output. Instantiated twice (X, Y) and driven by the shared divider/bit-index in xy2_100_tx.

Test Plan:
- Reset release, tx_en=1, no xy2_send -> first frame X=Y=0x0000: bits 0,0,1, sixteen 0s, parity 1. coord_ack stays 0. Frame length 1001 cycles.
- xy2_send pulse x=0x8000, y=0xFFFF during a frame -> next frame has X parity 0 and Y parity 1. coord_ack pulses once in LOAD. Subsequent frames repeat these values with coord_ack=0.
- Two xy2_send pulses (0x1234, then 0x0F0F) within one frame -> only 0x0F0F is transmitted. With XY2_STATUS_EN, overrun_cnt=1.
- xy2_send asserted exactly in the LOAD cycle -> the current frame carries the old value, the next frame carries the new one, and coord_ack pulses in both LOADs.
- tx_en dropped at bit 5 -> the frame completes all 20 bits with sync low on bit 19, then all outputs 0 and busy=0.
- reset asserted at bit 10 -> all outputs 0 within the same cycle. After release with tx_en=1, the first frame carries 0x0000.

Source files
------------

// File: rtl/xy2_pkg.sv
// Shared definitions for the XY2-100 transmitter.
//   FRAME_BITS : bits per XY2-100 frame
//   CTRL_BITS  : the three leading control bits of every frame
//   xy2_state_e: transmitter FSM states
//   xy2_frame(): builds a 20-bit frame {ctrl, coord, even parity}
package xy2_pkg;

    localparam int         FRAME_BITS = 20;
    localparam logic [2:0] CTRL_BITS  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } xy2_state_e;

    // Parity bit is the XOR of the other 19 bits, which makes the total
    // number of ones in the frame even.
    function automatic logic [FRAME_BITS-1:0] xy2_frame(input logic [15:0] coord);
        logic [FRAME_BITS-2:0] body;
        body = {CTRL_BITS, coord};
        return {body, ^body};
    endfunction

endpackage

// File: rtl/xy2_frame_shift.sv
// 20-bit load/shift register with MSB-first serial output.
// Ports:
//   clk, reset : system clock, asynchronous active-low reset
//   load       : parallel load of frame (has priority over shift)
//   shift      : shift left by one, zero fill
//   frame      : parallel frame value
//   sout       : current serial bit (register MSB)
module xy2_frame_shift
    import xy2_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  sout
);

    logic [FRAME_BITS-1:0] sr_q;
    logic [FRAME_BITS-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = frame;
        end else if (shift) begin
            sr_d = {sr_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sout = sr_q[FRAME_BITS-1];

endmodule

// File: rtl/xy2_100_tx.sv
// XY2-100 serial galvo transmitter. Buffers the newest coordinate sample and
// sends continuous 20-bit frames on the X and Y lines, repeating the last
// coordinate when no new sample has arrived.
// Parameter: HALF_PERIOD - clk cycles per half XY2 bit clock (>= 2).
// Ports:
//   clk, reset          : system clock, asynchronous active-low reset
//   tx_en               : 1 = transmit frames continuously
//   xy2_send            : sample valid for x_coord / y_coord
//   x_coord, y_coord    : 16-bit unsigned positions
//   xy2_clk, xy2_sync   : XY2 bit clock and frame sync
//   xy2_x, xy2_y        : serial data lines
//   coord_ack           : one-cycle pulse when a pending sample is loaded
//   busy                : 1 during LOAD and RUN
// Optional build macro XY2_STATUS_EN adds overrun_cnt[15:0] (saturating
// count of overwritten pending samples) and frame_cnt[31:0] (wrapping count
// of LOAD cycles).
module xy2_100_tx
    import xy2_pkg::*;
#(
    parameter int HALF_PERIOD = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_en,
    input  logic        xy2_send,
    input  logic [15:0] x_coord,
    input  logic [15:0] y_coord,
    output logic        xy2_clk,
    output logic        xy2_sync,
    output logic        xy2_x,
    output logic        xy2_y,
    output logic        coord_ack,
    output logic        busy
`ifdef XY2_STATUS_EN
    ,
    output logic [15:0] overrun_cnt,
    output logic [31:0] frame_cnt
`endif
);

    localparam int               DIV_W    = $clog2(2 * HALF_PERIOD);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * HALF_PERIOD - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(HALF_PERIOD);
    localparam logic [4:0]       BIT_LAST = 5'(FRAME_BITS - 1);

    xy2_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bit_q, bit_d;
    logic             pend_v_q, pend_v_d;
    logic [15:0]      pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [15:0]      held_x_q, held_x_d, held_y_q, held_y_d;
    logic             xy2_clk_q, xy2_clk_d, xy2_sync_q, xy2_sync_d;
    logic             xy2_x_q, xy2_x_d, xy2_y_q, xy2_y_d;
    logic             coord_ack_q, coord_ack_d, busy_q, busy_d;

    logic                  frame_load, frame_shift;
    logic                  x_sout, y_sout;
    logic [FRAME_BITS-1:0] frame_x, frame_y;

    assign frame_x = xy2_frame(held_x_d);
    assign frame_y = xy2_frame(held_y_d);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        pend_v_d    = pend_v_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        held_x_d    = held_x_q;
        held_y_d    = held_y_q;
        frame_load  = 1'b0;
        frame_shift = 1'b0;
        xy2_clk_d   = 1'b0;
        xy2_sync_d  = 1'b0;
        xy2_x_d     = 1'b0;
        xy2_y_d     = 1'b0;

        // Line outputs are registered decodes of the current state, so the
        // wire lags the internal state by one cycle.
        case (state_q)
            ST_IDLE: begin
                if (tx_en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                frame_load = 1'b1;
                div_d      = '0;
                bit_d      = '0;
                state_d    = ST_RUN;
                if (pend_v_q) begin
                    held_x_d = pend_x_q;
                    held_y_d = pend_y_q;
                    pend_v_d = 1'b0;
                end
                // Keep the parity bit on the data lines so data only ever
                // changes with a rising xy2_clk between back-to-back frames.
                xy2_x_d = xy2_x_q;
                xy2_y_d = xy2_y_q;
            end
            ST_RUN: begin
                xy2_clk_d  = (div_q < DIV_HALF);
                xy2_sync_d = (bit_q != BIT_LAST);
                xy2_x_d    = x_sout;
                xy2_y_d    = y_sout;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = tx_en ? ST_LOAD : ST_IDLE;
                    end else begin
                        bit_d       = bit_q + 5'd1;
                        frame_shift = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A sample arriving in LOAD lands after the copy above, so it stays
        // pending for the next frame.
        if (xy2_send) begin
            pend_v_d = 1'b1;
            pend_x_d = x_coord;
            pend_y_d = y_coord;
        end

        coord_ack_d = (state_d == ST_LOAD) && pend_v_d;
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            pend_v_q    <= 1'b0;
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            held_x_q    <= '0;
            held_y_q    <= '0;
            xy2_clk_q   <= 1'b0;
            xy2_sync_q  <= 1'b0;
            xy2_x_q     <= 1'b0;
            xy2_y_q     <= 1'b0;
            coord_ack_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            pend_v_q    <= pend_v_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            held_x_q    <= held_x_d;
            held_y_q    <= held_y_d;
            xy2_clk_q   <= xy2_clk_d;
            xy2_sync_q  <= xy2_sync_d;
            xy2_x_q     <= xy2_x_d;
            xy2_y_q     <= xy2_y_d;
            coord_ack_q <= coord_ack_d;
            busy_q      <= busy_d;
        end
    end

    xy2_frame_shift u_shift_x (
        .clk   (clk),
        .reset (reset),
        .load  (frame_load),
        .shift (frame_shift),
        .frame (frame_x),
        .sout  (x_sout)
    );

    xy2_frame_shift u_shift_y (
        .clk   (clk),
        .reset (reset),
        .load  (frame_load),
        .shift (frame_shift),
        .frame (frame_y),
        .sout  (y_sout)
    );

    assign xy2_clk   = xy2_clk_q;
    assign xy2_sync  = xy2_sync_q;
    assign xy2_x     = xy2_x_q;
    assign xy2_y     = xy2_y_q;
    assign coord_ack = coord_ack_q;
    assign busy      = busy_q;

`ifdef XY2_STATUS_EN
    logic [15:0] overrun_cnt_q, overrun_cnt_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;

    // A send in LOAD does not count: the pending sample is consumed that cycle.
    always_comb begin
        overrun_cnt_d = overrun_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        if (xy2_send && pend_v_q && (state_q != ST_LOAD) && (overrun_cnt_q != 16'hFFFF)) begin
            overrun_cnt_d = overrun_cnt_q + 16'd1;
        end
        if (state_q == ST_LOAD) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_cnt_q <= '0;
            frame_cnt_q   <= '0;
        end else begin
            overrun_cnt_q <= overrun_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign overrun_cnt = overrun_cnt_q;
    assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_xy2_100_tx.sv
// Testbench for xy2_100_tx: randomized and directed coordinate traffic, a
// frame-level reference model feeding an expected-frame queue, and a
// receiver-style monitor that decodes frames on falling xy2_clk edges.
module tb_xy2_100_tx;

    localparam int HP   = 25;
    localparam int FLEN = 40 * HP + 1;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        tx_en    = 1'b0;
    logic        xy2_send = 1'b0;
    logic [15:0] x_coord  = '0;
    logic [15:0] y_coord  = '0;
    logic        xy2_clk, xy2_sync, xy2_x, xy2_y, coord_ack, busy;
`ifdef XY2_STATUS_EN
    logic [15:0] overrun_cnt;
    logic [31:0] frame_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xy2_100_tx #(.HALF_PERIOD(HP)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_en     (tx_en),
        .xy2_send  (xy2_send),
        .x_coord   (x_coord),
        .y_coord   (y_coord),
        .xy2_clk   (xy2_clk),
        .xy2_sync  (xy2_sync),
        .xy2_x     (xy2_x),
        .xy2_y     (xy2_y),
        .coord_ack (coord_ack),
        .busy      (busy)
`ifdef XY2_STATUS_EN
        ,
        .overrun_cnt (overrun_cnt),
        .frame_cnt   (frame_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: control 0,0,1, coordinate MSB first, then the bit
    // that makes the count of ones even.
    function automatic logic [19:0] ref_frame(input logic [15:0] c);
        int ones;
        ones = 1 + $countones(c);
        return {3'b001, c, (ones % 2 == 1) ? 1'b1 : 1'b0};
    endfunction

    // ---------------- frame-level reference model ----------------
    // m_pos 0 is the LOAD cycle, 1..40*HP are the bit cycles.
    bit          m_frame = 0;
    int          m_pos   = 0;
    bit          m_pv    = 0;
    bit          m_prev_idle = 1;
    logic [15:0] m_px = '0, m_py = '0, m_hx = '0, m_hy = '0;
    int unsigned m_ovr   = 0;
    int unsigned m_loads = 0;
    logic [31:0] exp_q[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_frame = 0; m_pos = 0; m_pv = 0; m_prev_idle = 1;
            m_hx = '0; m_hy = '0; m_ovr = 0; m_loads = 0;
            exp_q.delete();
        end else begin
            m_prev_idle = !m_frame;
            if (m_frame && m_pos == 0) begin
                if (m_pv) begin
                    m_hx = m_px; m_hy = m_py; m_pv = 0;
                end
                exp_q.push_back({m_hx, m_hy});
                m_loads++;
            end
            if (xy2_send) begin
                if (m_pv && m_ovr < 32'hFFFF) m_ovr++;
                m_pv = 1; m_px = x_coord; m_py = y_coord;
            end
            if (!m_frame) begin
                if (tx_en) begin m_frame = 1; m_pos = 0; end
            end else if (m_pos == FLEN - 1) begin
                if (tx_en) m_pos = 0;
                else m_frame = 0;
            end else begin
                m_pos++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        mon_prev_clk = 1'b0;
    int          mon_nbits    = 0;
    logic [19:0] rx_x = '0, rx_y = '0;
    logic [31:0] exp_e;

    always @(negedge clk) begin
        if (!reset) begin
            mon_nbits    = 0;
            mon_prev_clk = 1'b0;
        end else begin
            check("busy", busy, m_frame);
            check("coord_ack", coord_ack, (m_frame && m_pos == 0 && m_pv));
            if (m_prev_idle) check("idle_lines", {xy2_clk, xy2_sync, xy2_x, xy2_y}, 4'b0000);
            if (mon_prev_clk && !xy2_clk) begin
                rx_x = {rx_x[18:0], xy2_x};
                rx_y = {rx_y[18:0], xy2_y};
                mon_nbits++;
                if (!xy2_sync) begin
                    check("frame_bits", mon_nbits, 20);
                    if (exp_q.size() == 0) begin
                        check("frame_expected", 1, 0);
                    end else begin
                        exp_e = exp_q.pop_front();
                        check("x_frame", rx_x, ref_frame(exp_e[31:16]));
                        check("y_frame", rx_y, ref_frame(exp_e[15:0]));
                    end
                    mon_nbits = 0;
                end
            end
            mon_prev_clk = xy2_clk;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_pos(input int p);
        bit ok = 0;
        for (int i = 0; i < 3 * FLEN; i++) begin
            @(negedge clk);
            if (m_frame && m_pos == p) begin ok = 1; break; end
        end
        if (!ok) check("wait_pos_timeout", 0, 1);
    endtask

    task automatic wait_frame_start(output int t);
        logic pc, ps;
        bit   ok = 0;
        t  = 0;
        pc = xy2_clk; ps = xy2_sync;
        for (int i = 0; i < 3 * FLEN; i++) begin
            @(negedge clk);
            if (xy2_clk && xy2_sync && !pc && !ps) begin ok = 1; t = $time / 10; break; end
            pc = xy2_clk; ps = xy2_sync;
        end
        if (!ok) check("frame_start_timeout", 0, 1);
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y);
        x_coord = x; y_coord = y; xy2_send = 1'b1;
        @(negedge clk);
        xy2_send = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int t0, t1;
        // Reset state
        tx_en = 1'b1;
        idle_cycles(3);
        #1;
        check("reset_outputs", {xy2_clk, xy2_sync, xy2_x, xy2_y, coord_ack, busy}, 6'b0);
        @(negedge clk);
        reset = 1'b1;

        // Frames of 0x0000 with no sample; frame period
        wait_frame_start(t0);
        wait_frame_start(t1);
        check("frame_period", t1 - t0, FLEN);

        // Single sample during a frame
        wait_pos(300);
        send(16'h8000, 16'hFFFF);
        wait_pos(0);
        wait_pos(0);
        wait_pos(200);

        // Two samples in one frame: newest wins
        send(16'h1234, 16'h4321);
        idle_cycles(100);
        send(16'h0F0F, 16'hF0F0);
        wait_pos(0);
        wait_pos(500);

        // Sample exactly in the LOAD cycle
        send(16'hAAAA, 16'h0001);
        wait_pos(0);
        x_coord = 16'h5555; y_coord = 16'h7FFE; xy2_send = 1'b1;
        @(negedge clk);
        xy2_send = 1'b0;
        wait_pos(0);
        wait_pos(10);

        // Randomized traffic
        for (int i = 0; i < 10 * FLEN; i++) begin
            x_coord  = 16'($urandom);
            y_coord  = 16'($urandom);
            xy2_send = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        xy2_send = 1'b0;

        // tx_en dropped at bit 5: frame completes, then lines idle
        wait_pos(1 + 5 * 2 * HP);
        tx_en = 1'b0;
        idle_cycles(FLEN);
        check("drop_busy", busy, 1'b0);
        check("drop_lines", {xy2_clk, xy2_sync, xy2_x, xy2_y}, 4'b0000);
        check("drop_queue_empty", exp_q.size(), 0);

        // Reset at bit 10 discards pending sample and held value
        tx_en = 1'b1;
        wait_pos(100);
        send(16'hBEEF, 16'hCAFE);
        wait_pos(0);
        send(16'h1357, 16'h2468);
        wait_pos(1 + 10 * 2 * HP);
        #2;
        reset = 1'b0;
        #1;
        check("reset_midframe", {xy2_clk, xy2_sync, xy2_x, xy2_y, coord_ack, busy}, 6'b0);
        idle_cycles(4);
        reset = 1'b1;
        wait_pos(0);
        wait_pos(0);
        wait_pos(400);

`ifdef XY2_STATUS_EN
        send(16'h0101, 16'h0202);
        send(16'h0303, 16'h0404);
        idle_cycles(2);
        check("overrun_cnt", overrun_cnt, m_ovr);
        check("frame_cnt", frame_cnt, m_loads);
`endif

        tx_en = 1'b0;
        idle_cycles(2 * FLEN);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

endmodule
